// File: rtl/data_memory_ctrl_pkg.sv
// Shared definitions for the RV32 data memory: funct3 codes, FSM states, error causes.
package riscx_mem_pkg;

    localparam int NUM_LANES = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} memState_t;

    typedef struct packed {
        logic illegal;
        logic misaligned;
        logic outOfRange;
    } mem_err_t;

    function automatic logic funct3Legal(input logic isWrite, input logic [2:0] f3);
        if (isWrite) return f3 inside {F3_B, F3_H, F3_W};
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

endpackage

// File: rtl/data_memory_ctrl_lane_align.sv
// Byte-lane steering: store byte enables / data replication, load extraction / extension.
module mem_lane_align
    import riscx_mem_pkg::*;
(
    input  logic [2:0]           stFunct3,
    input  logic [1:0]           stLane,
    input  logic [31:0]          stData,
    output logic [NUM_LANES-1:0] byteEn,
    output logic [31:0]          wrData,
    input  logic [2:0]           ldFunct3,
    input  logic [1:0]           ldLane,
    input  logic [31:0]          ldWord,
    output logic [31:0]          ldData
);

    for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
        localparam logic [1:0] LANE = 2'(g);
        assign byteEn[g] = !stFunct3[2] &&
                           ((stFunct3[1:0] == 2'b00) ? (stLane == LANE) :
                            (stFunct3[1:0] == 2'b01) ? (stLane[1] == LANE[1]) : 1'b1);
    end

    always_comb begin
        case (stFunct3[1:0])
            2'b00:   wrData = {4{stData[7:0]}};
            2'b01:   wrData = {2{stData[15:0]}};
            default: wrData = stData;
        endcase
    end

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    assign byteSel = ldWord[8*ldLane +: 8];
    assign halfSel = ldLane[1] ? ldWord[31:16] : ldWord[15:0];

    always_comb begin
        case (ldFunct3)
            F3_B:    ldData = {{24{byteSel[7]}}, byteSel};
            F3_H:    ldData = {{16{halfSel[15]}}, halfSel};
            F3_W:    ldData = ldWord;
            F3_BU:   ldData = {24'b0, byteSel};
            F3_HU:   ldData = {16'b0, halfSel};
            default: ldData = 32'b0;
        endcase
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressable RV32 data memory with valid/ready request and held response channel.
module data_memory_ctrl
    import riscx_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [1:0] WAIT_LOAD = (LATENCY > 1) ? 2'(LATENCY - 2) : 2'd0;

    memState_t             state, nextState;
    logic [1:0]            waitCnt;
    logic                  accept;
    mem_err_t              reqErr;
    logic                  reqErrAny;
    logic [31:0]           byteOff, wordOff;
    logic [AW-1:0]         wordIdx;
    logic [NUM_LANES-1:0]  byteEn;
    logic [31:0]           wrData, ldData;

    reg   [31:0]           mem [0:DEPTH_WORDS-1];
    logic [31:0]           rdWord;
    logic                  rspWrite, rspErr;
    logic [2:0]            rspFunct3;
    logic [1:0]            rspLane;

    // Reset takes priority over a simultaneously presented request.
    assign accept  = req_valid && req_ready && !reset;
    assign byteOff = req_addr - BASE_ADDR;
    assign wordOff = byteOff >> 2;
    assign wordIdx = wordOff[AW-1:0];

    always_comb begin
        reqErr            = '0;
        reqErr.outOfRange = (req_addr < BASE_ADDR) || (wordOff >= 32'(DEPTH_WORDS));
        reqErr.misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        reqErr.illegal    = !funct3Legal(req_write, req_funct3);
    end
    assign reqErrAny = |reqErr;

    mem_lane_align uAlign (
        .stFunct3 (req_funct3),
        .stLane   (req_addr[1:0]),
        .stData   (req_wdata),
        .byteEn   (byteEn),
        .wrData   (wrData),
        .ldFunct3 (rspFunct3),
        .ldLane   (rspLane),
        .ldWord   (rdWord),
        .ldData   (ldData)
    );

    // Read-first RAM with per-byte write enables; rdWord is the RAM output register.
    always_ff @(posedge clock) begin
        if (accept) begin
            rdWord <= mem[wordIdx];
            if (req_write && !reqErrAny) begin
                for (int b = 0; b < NUM_LANES; b++) begin
                    if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rspErr    <= 1'b0;
            rspWrite  <= 1'b0;
            rspFunct3 <= 3'b0;
            rspLane   <= 2'b0;
        end else if (accept) begin
            rspErr    <= reqErrAny;
            rspWrite  <= req_write;
            rspFunct3 <= req_funct3;
            rspLane   <= req_addr[1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= 2'd0;
        end else begin
            state <= nextState;
            if (accept)                             waitCnt <= WAIT_LOAD;
            else if (state == WAIT && waitCnt != 0) waitCnt <= waitCnt - 2'd1;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (accept) nextState = (LATENCY == 1) ? RESP : WAIT;
            WAIT:    if (waitCnt == 2'd0) nextState = RESP;
            RESP:    if (rsp_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        rsp_error = rsp_valid && rspErr;
        rsp_rdata = (rsp_valid && !rspErr && !rspWrite) ? ldData : 32'b0;
    end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed and random checks of data_memory_ctrl, one instance per LATENCY 1..4.
module tb_data_memory_ctrl;
    import riscx_mem_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                  reset;
    logic [3:0]            reqValid, reqReady, reqWrite, rspValid, rspReady, rspError;
    logic [3:0][2:0]       reqF3;
    logic [3:0][31:0]      reqAddr, reqWdata, rspRdata;

    int         nPass = 0;
    int         nTotal = 0;
    int         rspCount[4];
    logic [7:0] refMem[64];

    for (genvar g = 0; g < 4; g++) begin : gDut
        data_memory_ctrl #(.BASE_ADDR(BASE), .DEPTH_WORDS(256), .LATENCY(g + 1)) dut (
            .clock      (clock),
            .reset      (reset),
            .req_valid  (reqValid[g]),
            .req_ready  (reqReady[g]),
            .req_write  (reqWrite[g]),
            .req_funct3 (reqF3[g]),
            .req_addr   (reqAddr[g]),
            .req_wdata  (reqWdata[g]),
            .rsp_valid  (rspValid[g]),
            .rsp_ready  (rspReady[g]),
            .rsp_rdata  (rspRdata[g]),
            .rsp_error  (rspError[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic access(input int d, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        logic got;
        @(negedge clock);
        reqWrite[d] = wr; reqF3[d] = f3; reqAddr[d] = addr; reqWdata[d] = wdata;
        reqValid[d] = 1'b1; rspReady[d] = 1'b1;
        check("req_ready_idle", 32'(reqReady[d]), 32'd1);
        @(posedge clock);
        lat = 1;
        #1 reqValid[d] = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clock);
            if (rspValid[d]) got = 1'b1;
            else begin
                @(posedge clock);
                lat++;
            end
        end
        if (got) begin
            rdata = rspRdata[d];
            err   = rspError[d];
            rspCount[d]++;
            @(posedge clock);
        end else begin
            rdata = 32'hxxxx_xxxx;
            err   = 1'bx;
            lat   = -1;
        end
    endtask

    task automatic st(input int d, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic expErr, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        access(d, 1'b1, f3, addr, wdata, rd, er, lat);
        check({tag, ".lat"}, 32'(lat), 32'(d + 1));
        check({tag, ".err"}, {31'b0, er}, {31'b0, expErr});
        check({tag, ".rdata"}, rd, 32'h0);
    endtask

    task automatic ld(input int d, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] expData, input logic expErr, input string tag);
        logic [31:0] rd;
        logic        er;
        int          lat;
        access(d, 1'b0, f3, addr, 32'h0, rd, er, lat);
        check({tag, ".lat"}, 32'(lat), 32'(d + 1));
        check({tag, ".err"}, {31'b0, er}, {31'b0, expErr});
        check({tag, ".rdata"}, rd, expData);
    endtask

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic        got;
        logic [5:0]  off;
        int          size;
        logic        wr, uns, mis;
        logic [2:0]  f3;
        logic [31:0] data, expData, rd;
        logic        er;
        int          nReq;

        reset = 1'b1;
        reqValid = '0; reqWrite = '0; reqF3 = '0; reqAddr = '0; reqWdata = '0; rspReady = '1;
        foreach (rspCount[i]) rspCount[i] = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int d = 0; d < 4; d++) begin
            check("rst.req_ready", 32'(reqReady[d]), 32'd1);
            check("rst.rsp_valid", 32'(rspValid[d]), 32'd0);
            check("rst.rsp_rdata", rspRdata[d], 32'd0);
            check("rst.rsp_error", 32'(rspError[d]), 32'd0);
        end

        // Directed lane and error cases, LATENCY = 1
        st(0, F3_W, BASE + 32'h8,   32'h0,         1'b0, "init8");
        st(0, F3_W, BASE,           32'h1122_3344, 1'b0, "init0");
        st(0, F3_W, BASE + 32'h18,  32'h0,         1'b0, "init18");
        st(0, F3_W, BASE + 32'h3FC, 32'hA5A5_A5A5, 1'b0, "initTop");
        st(0, F3_W, BASE + 32'h4,   32'hDEAD_BEEF, 1'b0, "sw4");
        ld(0, F3_W, BASE + 32'h4,   32'hDEAD_BEEF, 1'b0, "lw4");
        st(0, F3_B, BASE + 32'h9,   32'h1234_5680, 1'b0, "sb9");
        ld(0, F3_B, BASE + 32'h9,   32'hFFFF_FF80, 1'b0, "lb9");
        ld(0, F3_BU, BASE + 32'h9,  32'h0000_0080, 1'b0, "lbu9");
        st(0, F3_H, BASE + 32'hA,   32'hABCD_8001, 1'b0, "shA");
        ld(0, F3_H, BASE + 32'hA,   32'hFFFF_8001, 1'b0, "lhA");
        ld(0, F3_HU, BASE + 32'hA,  32'h0000_8001, 1'b0, "lhuA");
        ld(0, F3_W, BASE + 32'h8,   32'h8001_8000, 1'b0, "lw8");
        ld(0, F3_W, BASE + 32'h2,   32'h0, 1'b1, "errLwMis");
        st(0, F3_H, BASE + 32'h1,   32'hFFFF, 1'b1, "errShMis");
        ld(0, F3_W, 32'h1000_FFFC,  32'h0, 1'b1, "errBelow");
        ld(0, F3_W, BASE + 32'h400, 32'h0, 1'b1, "errAbove");
        ld(0, 3'b011, BASE + 32'h4, 32'h0, 1'b1, "errLdF3");
        st(0, 3'b011, BASE + 32'h4, 32'h0, 1'b1, "errStF3a");
        st(0, F3_BU, BASE + 32'h4,  32'h0, 1'b1, "errStF3b");
        st(0, F3_W, BASE + 32'h400, 32'h1, 1'b1, "errStAbove");
        ld(0, F3_W, BASE,           32'h1122_3344, 1'b0, "keep0");
        ld(0, F3_W, BASE + 32'h4,   32'hDEAD_BEEF, 1'b0, "keep4");
        ld(0, F3_W, BASE + 32'h3FC, 32'hA5A5_A5A5, 1'b0, "lwTop");
        ld(0, F3_H, BASE + 32'h3FE, 32'hFFFF_A5A5, 1'b0, "lhTop");
        ld(0, F3_B, BASE + 32'h3FF, 32'hFFFF_FFA5, 1'b0, "lbTop");

        // Reset coincident with a request: the store must not land
        @(negedge clock);
        reset = 1'b1;
        reqWrite[0] = 1'b1; reqF3[0] = F3_W; reqAddr[0] = BASE + 32'h18;
        reqWdata[0] = 32'h5555_5555; reqValid[0] = 1'b1;
        @(posedge clock);
        #1 reqValid[0] = 1'b0; reset = 1'b0;
        @(negedge clock);
        check("rstReq.rsp_valid", 32'(rspValid[0]), 32'd0);
        check("rstReq.req_ready", 32'(reqReady[0]), 32'd1);
        ld(0, F3_W, BASE + 32'h18, 32'h0, 1'b0, "rstReq.noWrite");

        // Back-pressure, LATENCY = 3
        st(2, F3_W, BASE,          32'hCAFE_F00D, 1'b0, "bp.init0");
        st(2, F3_W, BASE + 32'h10, 32'h0,         1'b0, "bp.init10");
        @(negedge clock);
        reqWrite[2] = 1'b0; reqF3[2] = F3_W; reqAddr[2] = BASE; reqValid[2] = 1'b1; rspReady[2] = 1'b0;
        @(posedge clock);
        lat = 1;
        #1 reqWrite[2] = 1'b1; reqAddr[2] = BASE + 32'h10; reqWdata[2] = 32'h0BAD_0BAD;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clock);
            if (rspValid[2]) got = 1'b1;
            else begin
                @(posedge clock);
                lat++;
            end
        end
        check("bp.lat", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            check("bp.rsp_valid", 32'(rspValid[2]), 32'd1);
            check("bp.rsp_rdata", rspRdata[2], 32'hCAFE_F00D);
            check("bp.rsp_error", 32'(rspError[2]), 32'd0);
            check("bp.req_ready", 32'(reqReady[2]), 32'd0);
            @(posedge clock);
            @(negedge clock);
        end
        rspReady[2] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("bp.rel.rsp_valid", 32'(rspValid[2]), 32'd0);
        check("bp.rel.req_ready", 32'(reqReady[2]), 32'd1);
        reqValid[2] = 1'b0;
        ld(2, F3_W, BASE + 32'h10, 32'h0, 1'b0, "bp.ignored");

        // Reset while in WAIT after a store
        @(negedge clock);
        reqWrite[2] = 1'b1; reqF3[2] = F3_W; reqAddr[2] = BASE + 32'h14;
        reqWdata[2] = 32'h1234_5678; reqValid[2] = 1'b1;
        @(posedge clock);
        #1 reqValid[2] = 1'b0;
        @(negedge clock);
        check("rstWait.req_ready_busy", 32'(reqReady[2]), 32'd0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rstWait.req_ready", 32'(reqReady[2]), 32'd1);
        check("rstWait.rsp_valid", 32'(rspValid[2]), 32'd0);
        reset = 1'b0;
        got = 1'b0;
        repeat (4) begin
            @(negedge clock);
            if (rspValid[2]) got = 1'b1;
        end
        check("rstWait.noRsp", 32'(got), 32'd0);
        ld(2, F3_W, BASE + 32'h14, 32'h1234_5678, 1'b0, "rstWait.committed");

        // Random mixed-width traffic against a byte-array model, every LATENCY
        for (int d = 0; d < 4; d++) begin
            for (int w = 0; w < 16; w++) st(d, F3_W, BASE + 32'(w * 4), 32'h0, 1'b0, "rnd.init");
            foreach (refMem[i]) refMem[i] = 8'h0;
            rspCount[d] = 0;
            nReq = 0;
            for (int n = 0; n < 40; n++) begin
                off  = 6'($urandom_range(0, 63));
                size = $urandom_range(0, 2);
                wr   = 1'($urandom_range(0, 1));
                uns  = (size < 2) && ($urandom_range(0, 1) == 1);
                f3   = 3'(size) | (uns && !wr ? 3'b100 : 3'b000);
                mis  = (size == 1 && off[0]) || (size == 2 && off[1:0] != 2'b00);
                data = $urandom;
                expData = 32'h0;
                if (!mis && wr) begin
                    refMem[off] = data[7:0];
                    if (size >= 1) refMem[off + 1] = data[15:8];
                    if (size == 2) begin
                        refMem[off + 2] = data[23:16];
                        refMem[off + 3] = data[31:24];
                    end
                end else if (!mis) begin
                    case (size)
                        0: expData = uns ? {24'h0, refMem[off]} : {{24{refMem[off][7]}}, refMem[off]};
                        1: expData = uns ? {16'h0, refMem[off + 1], refMem[off]}
                                         : {{16{refMem[off + 1][7]}}, refMem[off + 1], refMem[off]};
                        default: expData = {refMem[off + 3], refMem[off + 2], refMem[off + 1], refMem[off]};
                    endcase
                end
                access(d, wr, f3, BASE + 32'(off), data, rd, er, lat);
                nReq++;
                check("rnd.lat", 32'(lat), 32'(d + 1));
                check("rnd.err", 32'(er), 32'(mis));
                check("rnd.rdata", rd, expData);
            end
            check("rnd.rspCount", 32'(rspCount[d]), 32'(nReq));
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
